// File: rtl/mem_write_checker.sv
// Snoops data-memory writes and checks them in order against a loadable table.
// Define MEM_WRITE_CHECKER_XCHECK_EN to flag X/Z on the write bus (fail_code 11).
module mem_write_checker #(
  parameter int WIDTH   = 32,
  parameter int NUM_EXP = 4,
  parameter int TIMEOUT = 150,
  parameter int TMO_W   = 16,
  localparam int IDX_W  = $clog2(NUM_EXP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [IDX_W:0]   exp_count,
  input  logic [WIDTH-1:0] ign_lo,
  input  logic [WIDTH-1:0] ign_hi,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [IDX_W:0]   match_count,
  output logic [7:0]       ign_count,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [IDX_W:0]   NUM_C    = NUM_EXP[IDX_W:0];
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tbl_addr_q [NUM_EXP];
  logic [WIDTH-1:0] tbl_addr_d [NUM_EXP];
  logic [WIDTH-1:0] tbl_data_q [NUM_EXP];
  logic [WIDTH-1:0] tbl_data_d [NUM_EXP];
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] ign_lo_q, ign_lo_d;
  logic [WIDTH-1:0] ign_hi_q, ign_hi_d;
  logic [IDX_W:0]   match_count_q, match_count_d;
  logic [7:0]       ign_count_q, ign_count_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;

  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   mc_inc;
  logic             hit, in_win, tmo, xbad;

  always_comb begin
    state_d       = state_q;
    tbl_addr_d    = tbl_addr_q;
    tbl_data_d    = tbl_data_q;
    cnt_d         = cnt_q;
    ign_lo_d      = ign_lo_q;
    ign_hi_d      = ign_hi_q;
    match_count_d = match_count_q;
    ign_count_d   = ign_count_q;
    timer_d       = timer_q;
    fail_code_d   = fail_code_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
`ifdef MEM_WRITE_CHECKER_XCHECK_EN
    xbad = $isunknown({dataadr, writedata});
`else
    xbad = 1'b0;
`endif
    idx    = match_count_q[IDX_W-1:0];
    mc_inc = match_count_q + 1'b1;
    hit    = (dataadr == tbl_addr_q[idx])
          && (writedata == tbl_data_q[idx]);
    in_win = (dataadr >= ign_lo_q) && (dataadr <= ign_hi_q);
    tmo    = (timer_q == TMO_LAST);

    unique case (state_q)
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        if (memwrite && xbad) begin
          state_d     = S_FAIL;
          fail_code_d = 2'b11;
          fail_addr_d = dataadr;
          fail_data_d = writedata;
        end else if (match_count_q == cnt_q) begin
          state_d = S_PASS;
        end else if (memwrite && hit) begin
          match_count_d = mc_inc;
          if (mc_inc == cnt_q) state_d = S_PASS;
        end else if (memwrite && in_win) begin
          if (ign_count_q != 8'hff) ign_count_d = ign_count_q + 1'b1;
        end else if (memwrite) begin
          state_d     = S_FAIL;
          fail_code_d = 2'b01;
          fail_addr_d = dataadr;
          fail_data_d = writedata;
        end
        // only a cycle that neither passed nor failed can time out
        if (state_d == S_RUN && tmo) begin
          state_d     = S_FAIL;
          fail_code_d = 2'b10;
        end
      end
      default: begin
        if (load_en && ({1'b0, load_idx} < NUM_C)) begin
          tbl_addr_d[load_idx] = load_addr;
          tbl_data_d[load_idx] = load_data;
        end
        if (start) begin
          state_d       = S_RUN;
          cnt_d         = (exp_count > NUM_C) ? NUM_C : exp_count;
          ign_lo_d      = ign_lo;
          ign_hi_d      = ign_hi;
          match_count_d = '0;
          ign_count_d   = '0;
          timer_d       = '0;
          fail_code_d   = '0;
          fail_addr_d   = '0;
          fail_data_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tbl_addr_q    <= '{default: '0};
      tbl_data_q    <= '{default: '0};
      cnt_q         <= '0;
      ign_lo_q      <= '0;
      ign_hi_q      <= '0;
      match_count_q <= '0;
      ign_count_q   <= '0;
      timer_q       <= '0;
      fail_code_q   <= '0;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      tbl_addr_q    <= tbl_addr_d;
      tbl_data_q    <= tbl_data_d;
      cnt_q         <= cnt_d;
      ign_lo_q      <= ign_lo_d;
      ign_hi_q      <= ign_hi_d;
      match_count_q <= match_count_d;
      ign_count_q   <= ign_count_d;
      timer_q       <= timer_d;
      fail_code_q   <= fail_code_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass        = (state_q == S_PASS);
  assign fail_code   = fail_code_q;
  assign match_count = match_count_q;
  assign ign_count   = ign_count_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scenario bench for mem_write_checker.
// Expected output snapshots are queued with stimulus, popped on DUT response.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr, writedata;
  logic        load_en;
  logic [1:0]  load_idx;
  logic [31:0] load_addr, load_data;
  logic [2:0]  exp_count;
  logic [31:0] ign_lo, ign_hi;
  logic        start;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [2:0]  match_count;
  logic [7:0]  ign_count;
  logic [31:0] fail_addr, fail_data;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  code;
    logic [2:0]  mc;
    logic [7:0]  ic;
    logic [31:0] fa;
    logic [31:0] fd;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, g;
  int   total = 0;
  int   passed = 0;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata),
    .load_en(load_en), .load_idx(load_idx),
    .load_addr(load_addr), .load_data(load_data),
    .exp_count(exp_count), .ign_lo(ign_lo), .ign_hi(ign_hi),
    .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .match_count(match_count),
    .ign_count(ign_count), .fail_addr(fail_addr),
    .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{busy, done, pass, fail_code, match_count,
             ign_count, fail_addr, fail_data};
  endfunction

  function automatic obs_t mk(bit b, bit d, bit p, bit [1:0] c,
                              bit [2:0] m, bit [7:0] i,
                              bit [31:0] a, bit [31:0] dd);
    return '{b, d, p, c, m, i, a, dd};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] i, input logic [31:0] a, d);
    load_en = 1'b1; load_idx = i; load_addr = a; load_data = d;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic go(input logic [2:0] cnt, input logic [31:0] lo, hi);
    exp_count = cnt; ign_lo = lo; ign_hi = hi; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    cyc();
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL reset_state: got %h want %h", g, e);
    else passed++;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_pass_ignore();
    load(0, 84, 7);
    go(1, 80, 80);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL run_entry: got %h want %h", g, e);
    else passed++;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    wr(80, 5);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL ign_write: got %h want %h", g, e);
    else passed++;
    exp_q.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0));
    wr(84, 7);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL match_pass: got %h want %h", g, e);
    else passed++;
    exp_q.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0));
    wr(88, 9);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL pass_hold: got %h want %h", g, e);
    else passed++;
  endtask

  task automatic test_mismatch();
    go(1, 80, 80);
    exp_q.push_back(mk(0, 1, 0, 2'b01, 0, 0, 88, 7));
    wr(88, 7);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL mismatch: got %h want %h", g, e);
    else passed++;
  endtask

  task automatic test_order();
    load(0, 80, 1);
    load(1, 84, 7);
    go(2, 1, 0);
    exp_q.push_back(mk(0, 1, 0, 2'b01, 0, 0, 84, 7));
    wr(84, 7);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL out_of_order: got %h want %h", g, e);
    else passed++;
    go(2, 1, 0);
    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    wr(80, 1);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL first_match: got %h want %h", g, e);
    else passed++;
    exp_q.push_back(mk(0, 1, 0, 2'b01, 1, 0, 80, 1));
    wr(80, 1);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL repeat_write: got %h want %h", g, e);
    else passed++;
  endtask

  task automatic test_timeout();
    int n;
    load(0, 84, 7);
    go(1, 1, 0);
    n = 0;
    while (!done && n < 400) begin
      cyc();
      n++;
    end
    total++;
    if (n !== 150) $display("FAIL tmo_edges: got %0d want 150", n);
    else passed++;
    exp_q.push_back(mk(0, 1, 0, 2'b10, 0, 0, 0, 0));
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL timeout: got %h want %h", g, e);
    else passed++;
    go(1, 1, 0);
    repeat (149) cyc();
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL pre_tmo: got %h want %h", g, e);
    else passed++;
    exp_q.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    wr(84, 7);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL tmo_pass: got %h want %h", g, e);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    load(0, 80, 1);
    load(1, 84, 7);
    go(2, 1, 0);
    wr(80, 1);
    #2 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL mid_reset: got %h want %h", g, e);
    else passed++;
    cyc();
    reset = 1'b1;
    cyc();
    go(1, 1, 0);
    exp_q.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    wr(0, 0);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL table_cleared: got %h want %h", g, e);
    else passed++;
    load(0, 80, 1);
    load(1, 84, 7);
    go(2, 1, 0);
    wr(80, 1);
    exp_q.push_back(mk(0, 1, 1, 0, 2, 0, 0, 0));
    wr(84, 7);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL rerun_pass: got %h want %h", g, e);
    else passed++;
  endtask

  task automatic test_zero_count();
    go(0, 1, 0);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL zero_run: got %h want %h", g, e);
    else passed++;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    cyc();
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL zero_pass: got %h want %h", g, e);
    else passed++;
  endtask

  task automatic test_load_start();
    load_en = 1'b1; load_idx = 0; load_addr = 90; load_data = 3;
    go(1, 1, 0);
    load_en = 1'b0;
    load(0, 44, 4);
    exp_q.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    wr(90, 3);
    e = exp_q.pop_front(); g = sample(); total++;
    if (g !== e) $display("FAIL load_start: got %h want %h", g, e);
    else passed++;
  endtask

  task automatic test_xcheck();
    logic [1:0] want;
`ifdef MEM_WRITE_CHECKER_XCHECK_EN
    want = 2'b11;
`else
    want = 2'b01;
`endif
    load(0, 84, 7);
    go(1, 1, 0);
    memwrite = 1'b1; dataadr = 88; writedata = 32'hxxxx0007;
    cyc();
    memwrite = 1'b0; writedata = 0;
    total++;
    if (fail_code !== want || done !== 1'b1)
      $display("FAIL xcheck: got code %b done %b want code %b done 1",
               fail_code, done, want);
    else passed++;
  endtask

  initial begin
    reset = 1'b0; memwrite = 0; dataadr = 0; writedata = 0;
    load_en = 0; load_idx = 0; load_addr = 0; load_data = 0;
    exp_count = 0; ign_lo = 0; ign_hi = 0; start = 0;
    test_reset();
    test_pass_ignore();
    test_mismatch();
    test_order();
    test_timeout();
    test_reset_midrun();
    test_zero_count();
    test_load_start();
    test_xcheck();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
